montgomery_sequencer: RTL and testbench

- Control FSM for the radix-4 Montgomery multiplier.
- Per 2-bit digit of operand A it drives the 3-bit operand-select code of the seven-input operand mux twice:
  - first to add digit*B;
  - then to add q*M, where q = (c_low * m_inv) mod 4.
- Around each add it handshakes with the wide adder, then pulses the accumulator and A shifters.
- After the last digit it requests the final conditional subtraction and reports completion.
- Sits between the top-level multiplier wrapper and the mux/adder/shift-register datapath.

---
 rtl/montgomery_sequencer.sv | 113 +++++++++++
 tb/tb_montgomery_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/montgomery_sequencer.sv
// Control FSM for the radix-4 Montgomery multiplier: walks the A digits, drives
// the operand-select mux, handshakes the wide adder, then requests the final subtraction.
module montgomery_sequencer #(
  parameter int N_BITS = 1024,
  parameter int DIGITS = N_BITS / 2,
  parameter int CNT_W  = $clog2(DIGITS)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] a_digit,
  input  logic [1:0] c_low,
  input  logic [1:0] m_inv,
  input  logic       add_done,
  input  logic       sub_done,
  output logic [2:0] sel,
  output logic       add_start,
  output logic       acc_shift,
  output logic       a_shift,
  output logic       final_sub,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, ADD_B, WAIT_B, ADD_M, WAIT_M, SHIFT, FINAL, WAIT_FINAL, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [2:0] sel_nxt, b_code, m_code;
  logic [1:0] q;
  logic       add_start_nxt, acc_shift_nxt, a_shift_nxt, final_sub_nxt, busy_nxt, done_nxt;

  // Digit d>0 selects (d)*B, encoded as {1, d-1}; digit 0 selects the zero operand.
  assign b_code = (a_digit == 2'd0) ? 3'b000 : {1'b1, a_digit - 2'd1};
  assign q      = c_low * m_inv;
  assign m_code = {1'b0, q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:       if (start) begin
                    state_nxt = ADD_B;
                    cnt_nxt   = '0;
                  end
      ADD_B:      state_nxt = WAIT_B;
      WAIT_B:     if (add_done) state_nxt = ADD_M;
      ADD_M:      state_nxt = WAIT_M;
      WAIT_M:     if (add_done) state_nxt = SHIFT;
      SHIFT:      if (cnt == CNT_W'(DIGITS - 1)) state_nxt = FINAL;
                  else begin
                    state_nxt = ADD_B;
                    cnt_nxt   = cnt + CNT_W'(1);
                  end
      FINAL:      state_nxt = WAIT_FINAL;
      WAIT_FINAL: if (sub_done) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // lines up with the state it belongs to without any input-to-output path.
  always_comb begin
    sel_nxt       = sel;
    add_start_nxt = (state_nxt == ADD_B) || (state_nxt == ADD_M);
    acc_shift_nxt = (state_nxt == SHIFT);
    a_shift_nxt   = (state_nxt == SHIFT);
    final_sub_nxt = (state_nxt == FINAL);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
    case (state_nxt)
      ADD_B:            sel_nxt = b_code;
      ADD_M:            sel_nxt = m_code;
      FINAL, DONE, IDLE: sel_nxt = 3'b000;
      default:          sel_nxt = sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= 3'b000;
      add_start <= 1'b0;
      acc_shift <= 1'b0;
      a_shift   <= 1'b0;
      final_sub <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sel       <= sel_nxt;
      add_start <= add_start_nxt;
      acc_shift <= acc_shift_nxt;
      a_shift   <= a_shift_nxt;
      final_sub <= final_sub_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_montgomery_sequencer.sv
// Directed bench for montgomery_sequencer with a small adder/subtractor responder.
module tb_montgomery_sequencer;
  localparam int N_BITS = 8;
  localparam int DIGITS = N_BITS / 2;

  logic       clk = 1'b0;
  logic       reset, start, add_done, sub_done;
  logic [1:0] a_digit, c_low, m_inv;
  logic [2:0] sel;
  logic       add_start, acc_shift, a_shift, final_sub, busy, done;

  montgomery_sequencer #(.N_BITS(N_BITS)) dut (
    .clk(clk), .reset(reset), .start(start), .a_digit(a_digit), .c_low(c_low),
    .m_inv(m_inv), .add_done(add_done), .sub_done(sub_done), .sel(sel),
    .add_start(add_start), .acc_shift(acc_shift), .a_shift(a_shift),
    .final_sub(final_sub), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Results of the last run
  int         r_done_t, r_nash, r_nadd, r_ndone, r_busy;
  logic [2:0] r_selb, r_selm, r_self, r_seld;
  bit         r_stable, r_restart;
  logic [8:0] r_abort_out;
  logic       r_abort_busy;

  function automatic int exp_done(input int l, input int s);
    return DIGITS * (2 * l + 3) + s + 2;
  endfunction

  // One operation: cycle 0 samples start; cycle t observed #1 after edge t.
  task automatic run(input int l, input int s, input logic [1:0] dig, input logic [1:0] cl,
                     input logic [1:0] mi, input bit spur, input bit stress, input int abort_add);
    int add_due, sub_due, add_t;
    logic [2:0] cur_sel;
    bit phase_m;
    add_due = -1; sub_due = -1; add_t = -1; phase_m = 1'b0; cur_sel = 3'b000;
    r_done_t = -1; r_nash = 0; r_nadd = 0; r_ndone = 0; r_busy = 0;
    r_selb = 3'bx; r_selm = 3'bx; r_self = 3'bx; r_seld = 3'bx;
    r_stable = 1'b1; r_restart = 1'b0; r_abort_out = 9'h1ff; r_abort_busy = 1'b1;
    @(posedge clk); #1;
    a_digit = dig; c_low = cl; m_inv = mi; start = 1'b1; add_done = 1'b0; sub_done = 1'b0;
    for (int t = 1; t < 400; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) r_busy++;
      if (a_shift) r_nash++;
      if (done) begin
        r_ndone++;
        r_seld = sel;
        if (r_done_t < 0) r_done_t = t;
      end
      if (add_t >= 0 && t > add_t && t <= add_due && sel !== cur_sel) r_stable = 1'b0;
      if (add_start) begin
        r_nadd++;
        cur_sel = sel; add_t = t; add_due = t + l;
        if (!phase_m) r_selb = sel; else r_selm = sel;
        phase_m = !phase_m;
      end
      if (final_sub) begin
        sub_due = t + s;
        r_self = sel;
      end
      if (abort_add > 0 && r_nadd == abort_add && t == add_t + 1) begin
        reset = 1'b1; add_done = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        r_abort_out = {sel, add_start, acc_shift, a_shift, final_sub, busy, done};
        @(posedge clk); #1;
        r_abort_busy = busy;
        break;
      end
      add_done = (t == add_due) || (spur && ((add_start && phase_m) || acc_shift));
      sub_done = (t == sub_due);
      if (stress && (t == 7 || t == r_done_t)) start = 1'b1;
      if (stress && r_done_t > 0 && t == r_done_t + 1) start = 1'b1;
      if (stress && r_done_t > 0 && t == r_done_t + 2) r_restart = busy;
      if (r_done_t > 0 && t == r_done_t + 3) break;
    end
    add_done = 1'b0; sub_done = 1'b0; start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; add_done = 1'b0; sub_done = 1'b0;
    a_digit = 2'd0; c_low = 2'd0; m_inv = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {sel, add_start, acc_shift, a_shift, final_sub, busy, done}, 9'd0);
    reset = 1'b0;

    // Baseline latency and select codes: digit 2 -> 2B, q = 3*1 = 3 -> 3M
    run(1, 1, 2'd2, 2'd3, 2'd1, 1'b0, 1'b0, 0);
    chk("lat_done_cycle", r_done_t, 23);
    chk("lat_a_shift_cnt", r_nash, DIGITS);
    chk("lat_add_cnt", r_nadd, 2 * DIGITS);
    chk("lat_done_cnt", r_ndone, 1);
    chk("lat_busy_cycles", r_busy, 23);
    chk("sel_b_d2", r_selb, 3'b101);
    chk("sel_m_q3", r_selm, 3'b011);
    chk("sel_final", r_self, 3'b000);
    chk("sel_done", r_seld, 3'b000);
    chk("sel_stable_l1", r_stable, 1'b1);

    // digit 1 -> B, q = 2*3 mod 4 = 2 -> 2M
    run(1, 1, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 0);
    chk("sel_b_d1", r_selb, 3'b100);
    chk("sel_m_q2", r_selm, 3'b010);

    // digit 3 -> 3B, q = 1*3 = 3 -> 3M
    run(1, 2, 2'd3, 2'd1, 2'd3, 1'b0, 1'b0, 0);
    chk("sel_b_d3", r_selb, 3'b110);
    chk("sel_m_q3b", r_selm, 3'b011);
    chk("s2_done_cycle", r_done_t, exp_done(1, 2));

    // Constant time with all-zero terms
    run(1, 1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 0);
    chk("zero_sel_b", r_selb, 3'b000);
    chk("zero_sel_m", r_selm, 3'b000);
    chk("zero_add_cnt", r_nadd, 2 * DIGITS);
    chk("zero_done_cycle", r_done_t, 23);

    // Slow adder with spurious add_done in ADD_B and SHIFT
    run(5, 2, 2'd2, 2'd3, 2'd1, 1'b1, 1'b0, 0);
    chk("l5_done_cycle", r_done_t, exp_done(5, 2));
    chk("l5_add_cnt", r_nadd, 2 * DIGITS);
    chk("l5_a_shift_cnt", r_nash, DIGITS);
    chk("l5_sel_stable", r_stable, 1'b1);
    chk("l5_done_cnt", r_ndone, 1);

    // Reset during WAIT_M of digit index 2 (sixth add request)
    run(3, 1, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 6);
    chk("abort_outputs", r_abort_out, 9'd0);
    chk("abort_idle", r_abort_busy, 1'b0);
    run(1, 1, 2'd2, 2'd3, 2'd1, 1'b0, 1'b0, 0);
    chk("post_abort_a_shift", r_nash, DIGITS);
    chk("post_abort_done", r_done_t, 23);

    // start while busy and in DONE is ignored; start right after DONE restarts
    run(1, 1, 2'd2, 2'd3, 2'd1, 1'b0, 1'b1, 0);
    chk("busy_start_done_cycle", r_done_t, 23);
    chk("busy_start_done_cnt", r_ndone, 1);
    chk("restart_after_done", r_restart, 1'b1);
    do_reset();
    #1;
    chk("final_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
